fetch_unit: RTL and testbench

Instruction-fetch front end for the IF stage of the five-stage pipeline. Holds the program counter, issues word reads to instruction memory over a request/ready handshake, and presents fetched instructions to the IF/ID boundary with a valid flag. Advances the PC by PC_STEP each fetch and accepts branch/jump redirects from later stages. Absorbs ID-stage back-pressure with a one-entry skid buffer, so no fetched instruction is lost.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, imem request/ready handshake, one-entry skid
// buffer for ID back-pressure, and a drain state that retires an outstanding read.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);
    typedef enum logic [1:0] {REQ, FULL, DRAIN} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] skid_instr, skid_instr_next, skid_pc, skid_pc_next;
    logic [31:0] drain_target, drain_target_next;
    logic        valid_next;
    logic [31:0] instr_next, opc_next, opc4_next;
    logic        accept;
    logic [31:0] target;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign imem_req  = reset && (state != FULL);
    assign imem_addr = {pc[31:2], 2'b00};
    assign accept    = imem_req && imem_ready;

    always_comb begin
        state_next        = state;
        pc_next           = pc;
        skid_instr_next   = skid_instr;
        skid_pc_next      = skid_pc;
        drain_target_next = drain_target;
        valid_next        = if_valid;
        instr_next        = if_instr;
        opc_next          = if_pc;
        opc4_next         = if_pc_plus4;
        case (state)
            REQ: begin
                if (accept && redirect) begin
                    pc_next    = target;
                    valid_next = 1'b0;
                end else if (redirect) begin
                    // Request already on the bus must complete before refetching.
                    valid_next        = 1'b0;
                    drain_target_next = target;
                    state_next        = DRAIN;
                end else if (accept && if_valid && stall) begin
                    skid_instr_next = imem_rdata;
                    skid_pc_next    = pc;
                    pc_next         = pc + PC_STEP;
                    state_next      = FULL;
                end else if (accept) begin
                    valid_next = 1'b1;
                    instr_next = imem_rdata;
                    opc_next   = pc;
                    opc4_next  = pc + PC_STEP;
                    pc_next    = pc + PC_STEP;
                end else if (!stall) begin
                    valid_next = 1'b0;
                end
            end
            FULL: begin
                if (redirect) begin
                    valid_next = 1'b0;
                    pc_next    = target;
                    state_next = REQ;
                end else if (!stall) begin
                    valid_next = 1'b1;
                    instr_next = skid_instr;
                    opc_next   = skid_pc;
                    opc4_next  = skid_pc + PC_STEP;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                valid_next = 1'b0;
                if (redirect) drain_target_next = target;
                if (accept) begin
                    pc_next    = redirect ? target : drain_target;
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= REQ;
            pc           <= RESET_PC;
            skid_instr   <= '0;
            skid_pc      <= '0;
            drain_target <= '0;
            if_valid     <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
            if_pc_plus4  <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            skid_instr   <= skid_instr_next;
            skid_pc      <= skid_pc_next;
            drain_target <= drain_target_next;
            if_valid     <= valid_next;
            if_instr     <= instr_next;
            if_pc        <= opc_next;
            if_pc_plus4  <= opc4_next;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset/wrap sequences.
module tb_fetch_unit;
    localparam logic [31:0] K = 32'h1357_9BDF;

    logic        clock = 1'b0;
    logic        reset, stall, redirect, imem_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4;
    logic        req2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2, pc4_2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Memory model: instruction word is a fixed function of its address.
    assign imem_rdata = imem_addr ^ K;
    assign rdata2     = addr2 ^ K;

    fetch_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(imem_ready), .imem_rdata(rdata2), .if_valid(valid2),
        .if_instr(instr2), .if_pc(pc2), .if_pc_plus4(pc4_2)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //            stall red  rpc           rdy  req  addr          vld  if_pc
        vecs[0]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0014};
        vecs[10] = '{1'b0, 1'b1, 32'h40,     1'b0, 1'b1, 32'h0000_0018, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_0018, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0018, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0040};
        vecs[15] = '{1'b1, 1'b1, 32'h103,    1'b1, 1'b0, 32'h0000_0048, 1'b1, 32'h0000_0040};
        vecs[16] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b1, 32'h200,    1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};
        vecs[18] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200};

        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_req",   {31'b0, imem_req}, 32'd0);
        check("reset_valid", {31'b0, if_valid}, 32'd0);
        check("reset_instr", if_instr, 32'd0);
        check("reset_pc",    if_pc, 32'd0);
        check("reset_pc4",   if_pc_plus4, 32'd0);

        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clock);
            reset       = 1'b1;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            imem_ready  = vecs[i].ready;
            #1;
            check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req)
                check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_pc", i),    if_pc, vecs[i].exp_pc);
                check($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_pc ^ K);
                check($sformatf("v%0d_pc4", i),   if_pc_plus4, vecs[i].exp_pc + 32'd4);
            end
        end

        // Enter DRAIN with a pending read, then reset mid-drain.
        @(negedge clock);
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h300; imem_ready = 1'b0;
        @(negedge clock);
        redirect = 1'b0; reset = 1'b0;
        #1 check("drain_rst_req_gated", {31'b0, imem_req}, 32'd0);
        @(negedge clock);
        check("drain_rst_req",   {31'b0, imem_req}, 32'd0);
        check("drain_rst_valid", {31'b0, if_valid}, 32'd0);
        check("drain_rst_instr", if_instr, 32'd0);
        check("drain_rst_pc",    if_pc, 32'd0);
        check("drain_rst_pc4",   if_pc_plus4, 32'd0);

        // Restart: main DUT from 0, wrap DUT across 2^32.
        reset = 1'b1; imem_ready = 1'b1;
        #1;
        check("restart_addr",  imem_addr, 32'h0);
        check("restart_req",   {31'b0, imem_req}, 32'd1);
        check("restart_valid", {31'b0, if_valid}, 32'd0);
        check("wrap_addr0",    addr2, 32'hFFFF_FFF8);
        @(negedge clock);
        check("restart_pc",    if_pc, 32'h0);
        check("restart_vld1",  {31'b0, if_valid}, 32'd1);
        check("restart_addr1", imem_addr, 32'h4);
        check("wrap_addr1",    addr2, 32'hFFFF_FFFC);
        check("wrap_pc0",      pc2, 32'hFFFF_FFF8);
        check("wrap_pc4_0",    pc4_2, 32'hFFFF_FFFC);
        @(negedge clock);
        check("wrap_addr2",    addr2, 32'h0000_0000);
        check("wrap_pc1",      pc2, 32'hFFFF_FFFC);
        check("wrap_pc4_1",    pc4_2, 32'h0000_0000);
        check("wrap_instr1",   instr2, 32'hFFFF_FFFC ^ K);
        @(negedge clock);
        check("wrap_pc2",      pc2, 32'h0000_0000);
        check("wrap_pc4_2",    pc4_2, 32'h0000_0004);
        check("wrap_valid",    {31'b0, valid2}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
